// File: rtl/time_entry_pkg.sv
// Shared timer package: FSM state encoding, BCD digit geometry and a key
// legality helper used by the time-entry front end.
package time_entry_pkg;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DIGITS_W   = DIGIT_W * NUM_DIGITS;
  localparam int unsigned NDIG_W     = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENTRY  = 2'd1,
    ST_LOAD   = 2'd2,
    ST_LOCKED = 2'd3
  } state_e;

  // A keypad code is a usable digit only when it is a legal BCD value.
  function automatic logic is_bcd(input logic [DIGIT_W-1:0] code);
    return (code <= 4'd9);
  endfunction

endpackage

// File: rtl/time_entry_bcd_shift4.sv
// Four-digit BCD shift register. New digits enter at the least significant
// position (seconds ones); clear has priority over shift.
module bcd_shift4
  import time_entry_pkg::*;
(
  input  logic                clk,
  input  logic                clrn,
  input  logic                clr_i,
  input  logic                shift_i,
  input  logic [DIGIT_W-1:0]  digit_i,
  output logic [DIGITS_W-1:0] digits_o
);

  logic [DIGITS_W-1:0] digits_q;
  logic [DIGITS_W-1:0] digits_d;

  // Next-digit selection: clear wins, otherwise shift left and insert.
  always_comb begin
    digits_d = digits_q;
    if (clr_i) begin
      digits_d = '0;
    end else if (shift_i) begin
      digits_d = {digits_q[DIGITS_W-DIGIT_W-1:0], digit_i};
    end else begin
      digits_d = digits_q;
    end
  end

  // Digit storage with asynchronous clear.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      digits_q <= '0;
    end else begin
      digits_q <= digits_d;
    end
  end

  assign digits_o = digits_q;

endmodule

// File: rtl/time_entry.sv
// Keypad time-entry controller for a countdown timer: collects up to four
// BCD digits, validates a start request, issues a one-cycle active-low load
// strobe and holds the value locked until the timer finishes or is cleared.
module time_entry
  import time_entry_pkg::*;
#(
  parameter int unsigned SEC_TENS_MAX = 5
) (
  input  logic                clk,
  input  logic                clrn,
  input  logic                key_valid,
  input  logic [DIGIT_W-1:0]  key,
  input  logic                start,
  input  logic                clear,
  input  logic                done,
  output logic [DIGITS_W-1:0] digits,
  output logic                loadn,
  output logic [NDIG_W-1:0]   ndig,
  output logic                locked,
  output logic                err,
  output logic                stop
);

  state_e              state_q, state_d;
  logic [NDIG_W-1:0]   ndig_q, ndig_d;
  logic                loadn_q, locked_q, err_q, stop_q;
  logic                err_d, stop_d;
  logic                clr_s, shift_s;
  logic [DIGITS_W-1:0] digits_s;
  logic [DIGIT_W-1:0]  sec_tens_s;
  logic                start_ok_s;
  logic                key_ok_s;

  bcd_shift4 u_shift (
    .clk      (clk),
    .clrn     (clrn),
    .clr_i    (clr_s),
    .shift_i  (shift_s),
    .digit_i  (key),
    .digits_o (digits_s)
  );

  assign sec_tens_s = digits_s[2*DIGIT_W-1:DIGIT_W];
  assign start_ok_s = (state_q == ST_ENTRY) &&
                      (32'(sec_tens_s) <= SEC_TENS_MAX) &&
                      (digits_s != '0);
  assign key_ok_s   = key_valid && is_bcd(key) && (ndig_q < 3'd4);

  // Event arbitration per state: clear > start > key; LOAD ignores everything.
  always_comb begin
    state_d = state_q;
    ndig_d  = ndig_q;
    err_d   = 1'b0;
    stop_d  = 1'b0;
    clr_s   = 1'b0;
    shift_s = 1'b0;
    case (state_q)
      ST_IDLE, ST_ENTRY: begin
        if (clear) begin
          clr_s   = 1'b1;
          ndig_d  = 3'd0;
          state_d = ST_IDLE;
        end else if (start) begin
          if (start_ok_s) begin
            state_d = ST_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end else if (key_ok_s) begin
          shift_s = 1'b1;
          ndig_d  = ndig_q + 3'd1;
          state_d = ST_ENTRY;
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD: begin
        state_d = ST_LOCKED;
      end
      ST_LOCKED: begin
        if (clear) begin
          stop_d  = 1'b1;
          clr_s   = 1'b1;
          ndig_d  = 3'd0;
          state_d = ST_IDLE;
        end else if (done) begin
          clr_s   = 1'b1;
          ndig_d  = 3'd0;
          state_d = ST_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        clr_s   = 1'b1;
        ndig_d  = 3'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state and registered outputs derived from the next state.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q  <= ST_IDLE;
      ndig_q   <= 3'd0;
      loadn_q  <= 1'b1;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      stop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ndig_q   <= ndig_d;
      loadn_q  <= (state_d != ST_LOAD);
      locked_q <= (state_d == ST_LOCKED);
      err_q    <= err_d;
      stop_q   <= stop_d;
    end
  end

  assign digits = digits_s;
  assign ndig   = ndig_q;
  assign loadn  = loadn_q;
  assign locked = locked_q;
  assign err    = err_q;
  assign stop   = stop_q;

endmodule

// File: tb/tb_time_entry.sv
// Self-checking bench for time_entry: a queue-based behavioural model checked
// every falling edge, plus directed scenarios with literal expectations.
module tb_time_entry;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key = 4'd0;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic        done = 1'b0;
  logic [15:0] digits;
  logic        loadn;
  logic [2:0]  ndig;
  logic        locked;
  logic        err;
  logic        stop;

  int n_tests = 0;
  int n_fail  = 0;

  time_entry #(.SEC_TENS_MAX(5)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .key_valid (key_valid),
    .key       (key),
    .start     (start),
    .clear     (clear),
    .done      (done),
    .digits    (digits),
    .loadn     (loadn),
    .ndig      (ndig),
    .locked    (locked),
    .err       (err),
    .stop      (stop)
  );

  always #5 clk = ~clk;

  // Model: entered digits kept as a queue; phase is a plain activity label.
  localparam int P_IDLE = 0, P_ENTRY = 1, P_LOAD = 2, P_RUN = 3;
  int mq[$];
  int phase = P_IDLE;
  bit e_loadn = 1'b1, e_locked = 1'b0, e_err = 1'b0, e_stop = 1'b0;

  function automatic int model_value();
    int v = 0;
    foreach (mq[i]) v = v * 16 + mq[i];
    return v;
  endfunction

  always @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      mq.delete();
      phase = P_IDLE;
      e_loadn = 1'b1; e_locked = 1'b0; e_err = 1'b0; e_stop = 1'b0;
    end else begin
      e_err = 1'b0;
      e_stop = 1'b0;
      if (phase == P_LOAD) begin
        phase = P_RUN;
      end else if (clear) begin
        if (phase == P_RUN) e_stop = 1'b1;
        mq.delete();
        phase = P_IDLE;
      end else if (phase == P_RUN) begin
        if (done) begin
          mq.delete();
          phase = P_IDLE;
        end
      end else if (start) begin
        if (phase == P_ENTRY && ((model_value() / 16) % 16) <= 5 && model_value() != 0)
          phase = P_LOAD;
        else
          e_err = 1'b1;
      end else if (key_valid && key <= 4'd9 && mq.size() < 4) begin
        mq.push_back(int'(key));
        phase = P_ENTRY;
      end
      e_loadn = (phase != P_LOAD);
      e_locked = (phase == P_RUN);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("m_digits", int'(digits), model_value());
    chk("m_ndig",   int'(ndig),   mq.size());
    chk("m_loadn",  int'(loadn),  int'(e_loadn));
    chk("m_locked", int'(locked), int'(e_locked));
    chk("m_err",    int'(err),    int'(e_err));
    chk("m_stop",   int'(stop),   int'(e_stop));
  end

  task automatic cyc(input bit kv, input int k, input bit st, input bit cl, input bit dn);
    @(negedge clk);
    #1;
    key_valid = kv; key = 4'(k); start = st; clear = cl; done = dn;
    @(posedge clk);
    #1;
    key_valid = 1'b0; key = 4'd0; start = 1'b0; clear = 1'b0; done = 1'b0;
  endtask

  task automatic press(input int k);
    cyc(1'b1, k, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_digits"}, int'(digits), 0);
    chk({tag, "_ndig"},   int'(ndig),   0);
    chk({tag, "_loadn"},  int'(loadn),  1);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_err"},    int'(err),    0);
    chk({tag, "_stop"},   int'(stop),   0);
  endtask

  initial begin
    #12;
    chk_reset_vals("rst");
    @(negedge clk); #1; clrn = 1'b1;

    // Entry 1,3,0 then start.
    press(1); press(3); press(0);
    chk("entry_digits", int'(digits), 'h0130);
    chk("entry_ndig", int'(ndig), 3);
    cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
    chk("load_loadn", int'(loadn), 0);
    chk("load_locked", int'(locked), 0);
    idle();
    chk("locked_loadn", int'(loadn), 1);
    chk("locked_locked", int'(locked), 1);
    chk("locked_digits", int'(digits), 'h0130);
    press(7);
    cyc(1'b0, 0, 1'b1, 1'b0, 1'b1 == 1'b0);
    chk("locked_frozen", int'(digits), 'h0130);
    cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
    chk("clr_run_stop", int'(stop), 1);
    chk("clr_run_digits", int'(digits), 0);
    idle();
    chk("stop_one_cycle", int'(stop), 0);

    // Overflow and illegal key.
    press(1); press(2); press(3); press(4); press(5); press(12);
    chk("ovf_digits", int'(digits), 'h1234);
    chk("ovf_ndig", int'(ndig), 4);
    cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
    chk("clr_entry_stop", int'(stop), 0);

    // Rejected starts.
    press(1); press(7); press(0);
    cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
    chk("rej_err", int'(err), 1);
    chk("rej_loadn", int'(loadn), 1);
    chk("rej_digits", int'(digits), 'h0170);
    idle();
    chk("rej_err_pulse", int'(err), 0);
    cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
    chk("idle_start_err", int'(err), 1);
    press(0); press(0);
    cyc(1'b1, 5, 1'b1, 1'b0, 1'b0);
    chk("zero_start_err", int'(err), 1);
    chk("zero_start_ndig", int'(ndig), 2);
    cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);

    // Done outside a run is ignored, then a full run ending in done.
    press(5);
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);
    chk("done_ignored", int'(digits), 'h0005);
    cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b1, 1'b1);
    chk("load_ignores_clear", int'(locked), 1);
    idle(); idle();
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);
    chk("done_locked", int'(locked), 0);
    chk("done_digits", int'(digits), 0);
    chk("done_no_stop", int'(stop), 0);
    press(9);
    chk("after_done_key", int'(digits), 'h0009);
    chk("after_done_ndig", int'(ndig), 1);

    // Priority: clear + start + key in ENTRY.
    press(2);
    cyc(1'b1, 3, 1'b1, 1'b1, 1'b0);
    chk("prio_digits", int'(digits), 0);
    chk("prio_ndig", int'(ndig), 0);
    chk("prio_loadn", int'(loadn), 1);
    chk("prio_err", int'(err), 0);
    idle();
    chk("prio_loadn2", int'(loadn), 1);

    // Asynchronous reset during a run.
    press(1); press(2);
    cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
    idle();
    chk("pre_rst_locked", int'(locked), 1);
    @(negedge clk); #1;
    clrn = 1'b0;
    #1;
    chk_reset_vals("arst");
    idle();
    chk_reset_vals("arst_hold");
    @(negedge clk); #1; clrn = 1'b1;
    idle();
    chk_reset_vals("arst_after");
    press(4);
    chk("post_rst_key", int'(digits), 'h0004);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/time_entry.md
TIME_ENTRY -- requirements
Module: time_entry

Interface
REQ-001 SHALL have parameter SEC_TENS_MAX, default 5, the largest legal seconds-tens digit at start.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port clrn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port key_valid  input  1  one-cycle strobe qualifying key.
REQ-005 SHALL have port key  input  4  keypad BCD digit; codes 10-15 are illegal.
REQ-006 SHALL have port start  input  1  one-cycle start request.
REQ-007 SHALL have port clear  input  1  one-cycle clear/cancel request.
REQ-008 SHALL have port done  input  1  one-cycle pulse from the countdown timer when it reaches 00:00.
REQ-009 SHALL have port digits  output  16  {min_tens, min_ones, sec_tens, sec_ones}, 4 bits each; drives the timer digit counters' load data.
REQ-010 SHALL have port loadn  output  1  active-low one-cycle load strobe to the timer digit counters.
REQ-011 SHALL have port ndig  output  3  number of digits entered, 0-4.
REQ-012 SHALL have port locked  output  1  high while the timer runs a loaded value.
REQ-013 SHALL have port err  output  1  one-cycle pulse on a rejected start.
REQ-014 SHALL have port stop  output  1  one-cycle pulse on a clear during a run.

Function
REQ-015 SHALL implement FSM states IDLE, ENTRY, LOAD, LOCKED; all outputs registered.
REQ-016 SHALL, in IDLE or ENTRY, on key_valid with key<=9 and ndig<4, shift digits left 4 bits, insert key at sec_ones, increment ndig, and go to ENTRY.
REQ-017 SHALL ignore key_valid with key>9, with ndig=4, or in LOAD/LOCKED: no state, digit or ndig change.
REQ-018 SHALL, on start in ENTRY with sec_tens<=SEC_TENS_MAX and digits nonzero, go to LOAD.
REQ-019 SHALL, on start in IDLE, start with digits all zero, or start with sec_tens>SEC_TENS_MAX, pulse err the next cycle and keep state and digits unchanged.
REQ-020 SHALL drive loadn low for exactly the one cycle spent in LOAD, with digits stable during and after it, then go to LOCKED.
REQ-021 SHALL hold locked=1 throughout LOCKED and keep digits frozen there.
REQ-022 SHALL, on done in LOCKED, clear digits and ndig and go to IDLE.
REQ-023 SHALL, on clear in LOCKED, pulse stop the next cycle, clear digits and ndig, and go to IDLE.
REQ-024 SHALL, on clear in IDLE or ENTRY, clear digits and ndig and go to IDLE with no stop pulse.
REQ-025 SHALL resolve same-cycle events by priority clear > start > key_valid; lower-priority events are dropped.
REQ-026 SHALL ignore start, clear and done in LOAD; SHALL ignore done outside LOCKED.

Reset
REQ-027 SHALL, while clrn=0 (asynchronously), force state IDLE, digits=0, ndig=0, loadn=1, locked=0, err=0, stop=0.
REQ-028 SHALL, on reset mid-LOAD or mid-LOCKED, abandon the run with no loadn or stop pulse emitted.

Structure
REQ-029 SHALL take the FSM state encoding, the BCD digit width (4) and the digit count (4) from the shared timer package.
REQ-030 SHALL place the 4-digit BCD shift register with clear in one sub-module, bcd_shift4.

Verification
REQ-031 SHALL cover entry: keys 1,3,0 then start -> digits=16'h0130, ndig=3, one loadn-low cycle, then locked=1.
REQ-032 SHALL cover overflow and illegal keys: keys 1,2,3,4,5 and key 12 -> digits=16'h1234, ndig=4.
REQ-033 SHALL cover rejected starts: keys 1,7,0 then start -> err pulse, loadn stays 1, digits=16'h0170; start from IDLE -> err pulse.
REQ-034 SHALL cover run end: load 16'h0005, done pulse -> locked=0, digits=0, state IDLE; a key is accepted the next cycle.
REQ-035 SHALL cover priority: clear+start+key_valid in the same cycle in ENTRY -> IDLE, digits=0, no loadn, no err; clear in LOCKED -> stop pulse.
REQ-036 SHALL cover async reset: clrn low mid-LOCKED -> all outputs at reset values before the next clk edge.
